// File: rtl/ddr_rx_align_ctrl_if.sv
// Word delivery channel from the alignment controller to the receive-side
// consumer: aligned data plus a valid/ready handshake.
interface ddr_rx_align_ctrl_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  // Controller side: drives data/valid, observes ready.
  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  // Consumer side: observes data/valid, drives ready.
  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/ddr_rx_align_ctrl.sv
// IDDR sequencing and word-alignment controller.
// Owns the IDDR reset/clock-enable, trains on a sync word by bit-slipping a
// capture window over a 2*WORD_W bit history, then streams aligned words
// over a valid/ready channel with single-word buffering and sticky overflow.
module ddr_rx_align_ctrl #(
  parameter int              WORD_W     = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD  = 8'hA5,
  parameter int              LOCK_COUNT = 4,
  parameter int              TIMEOUT    = 64
) (
  input  logic                      clk_in,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      iddr_q1,
  input  logic                      iddr_q2,
  output logic                      iddr_ce,
  output logic                      iddr_rst,
  output logic                      locked,
  output logic                      train_fail,
  output logic                      overflow,
  output logic [$clog2(WORD_W)-1:0] slip_offs,
  ddr_rx_align_ctrl_if.master       word_if
);

  localparam int HALF       = WORD_W / 2;
  localparam int PH_W       = $clog2(HALF);
  localparam int SLIP_W     = $clog2(WORD_W);
  localparam int CNT_W      = $clog2(WORD_W);
  localparam int ATT_W      = $clog2(TIMEOUT + 1);
  localparam int MATCH_W    = $clog2(LOCK_COUNT + 1);
  localparam int HIST_W     = 2 * WORD_W - 2;
  localparam int RST_CYCLES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_FLUSH,
    S_SEARCH,
    S_VERIFY,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t               state;
  logic [HIST_W-1:0]    hist;       // older bits; the two oldest of the full window are never needed again
  logic [PH_W-1:0]      phase;
  logic [CNT_W-1:0]     cnt;        // cycle counter for RST and FLUSH
  logic [MATCH_W-1:0]   match_cnt;
  logic [ATT_W-1:0]     attempts;

  logic [2*WORD_W-1:0]  cap_word;   // full window including this cycle's two bits
  logic [WORD_W-1:0]    candidate;
  logic                 boundary;
  logic                 restart;
  logic [SLIP_W-1:0]    slip_next;

  assign cap_word  = {hist, iddr_q1, iddr_q2};
  // Window starts slip_offs bits after the oldest bit; MSB is the earliest bit.
  assign candidate = WORD_W'(cap_word >> (WORD_W - int'(slip_offs)));
  assign boundary  = iddr_ce && (phase == PH_W'(HALF - 1));
  assign restart   = start && (state == S_IDLE || state == S_LOCKED || state == S_FAIL);
  assign slip_next = (slip_offs == SLIP_W'(WORD_W - 1)) ? '0 : slip_offs + 1'b1;

  // Capture path: shift in both IDDR bits and track the word phase while enabled.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the bit history is cleared on reset so the first candidates after
      // power-up are deterministic rather than X; FLUSH overwrites it anyway.
      hist  <= '0;
      phase <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (iddr_ce) begin
        hist  <= cap_word[HIST_W-1:0];
        phase <= (phase == PH_W'(HALF - 1)) ? '0 : phase + 1'b1;
      end
      if (state == S_RST) begin
        phase <= '0;
      end
    end
  end

  // Training FSM with registered IDDR controls, status flags and word output.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      cnt                <= '0;
      match_cnt          <= '0;
      attempts           <= '0;
      slip_offs          <= '0;
      iddr_rst           <= 1'b1;
      iddr_ce            <= 1'b0;
      locked             <= 1'b0;
      train_fail         <= 1'b0;
      overflow           <= 1'b0;
      word_if.word_data  <= '0;
      word_if.word_valid <= 1'b0;
    end else if (restart) begin
      state              <= S_RST;
      cnt                <= '0;
      match_cnt          <= '0;
      attempts           <= '0;
      slip_offs          <= '0;
      overflow           <= 1'b0;
      iddr_rst           <= 1'b1;
      iddr_ce            <= 1'b0;
      locked             <= 1'b0;
      train_fail         <= 1'b0;
      word_if.word_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          iddr_rst <= 1'b1;
          iddr_ce  <= 1'b0;
        end

        S_RST: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            state    <= S_FLUSH;
            cnt      <= '0;
            iddr_rst <= 1'b0;
            iddr_ce  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_FLUSH: begin
          if (cnt == CNT_W'(WORD_W - 1)) begin
            state <= S_SEARCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_SEARCH: begin
          if (boundary) begin
            if (candidate == SYNC_WORD) begin
              match_cnt <= MATCH_W'(1);
              if (LOCK_COUNT == 1) begin
                state  <= S_LOCKED;
                locked <= 1'b1;
              end else begin
                state <= S_VERIFY;
              end
            end else begin
              slip_offs <= slip_next;
              attempts  <= attempts + 1'b1;
              if (attempts == ATT_W'(TIMEOUT - 1)) begin
                state      <= S_FAIL;
                train_fail <= 1'b1;
                iddr_rst   <= 1'b1;
                iddr_ce    <= 1'b0;
              end
            end
          end
        end

        S_VERIFY: begin
          if (boundary) begin
            if (candidate == SYNC_WORD) begin
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                state  <= S_LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
              slip_offs <= slip_next;
              state     <= S_SEARCH;
            end
          end
        end

        S_LOCKED: begin
          // Consumer still holding a word: keep it, drop any new one.
          if (word_if.word_valid && !word_if.word_ready) begin
            if (boundary) begin
              overflow <= 1'b1;
            end
          end else if (boundary) begin
            word_if.word_data  <= candidate;
            word_if.word_valid <= 1'b1;
          end else if (word_if.word_valid) begin
            word_if.word_valid <= 1'b0;
          end
        end

        S_FAIL: begin
          iddr_rst <= 1'b1;
          iddr_ce  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
